// File: rtl/rv_pkg.sv
// Shared RV32 definitions: opcodes, the bubble instruction and immediate
// extraction helpers used by both fetch and decode.
package rv_pkg;

  localparam logic [6:0] OP_CONDITIONAL_JMP   = 7'b1100011;
  localparam logic [6:0] OP_UNCONDITIONAL_JMP = 7'b1101111;
  localparam logic [6:0] OP_INDIRECT_JMP      = 7'b1100111;
  localparam logic [6:0] OP_IMM               = 7'b0010011;
  localparam logic [6:0] OP_REG               = 7'b0110011;
  localparam logic [6:0] OP_LOAD              = 7'b0000011;
  localparam logic [6:0] OP_STORE             = 7'b0100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_bht.sv
// Branch history table: 2**IDX_W saturating 2-bit counters, combinational
// lookup port and one clocked update port.
module if_bht #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] ctr [DEPTH];

  // Lookup reads the registered array, so a same-cycle update is not visible.
  assign rd_ctr = ctr[rd_idx];

  // NOTE: the counter array is reset in flops on purpose; every entry must be
  // weakly not-taken after reset, which a RAM macro could not provide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= 2'b01;
    end else if (upd_valid) begin
      if (upd_taken && ctr[upd_idx] != 2'b11)
        ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
      else if (!upd_taken && ctr[upd_idx] != 2'b00)
        ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, BHT-based direction prediction with target
// computation, and the IF/ID pipeline register feeding decode.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 6,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        bht_update_valid,
  input  logic [31:0] bht_update_pc,
  input  logic        bht_update_taken,
  output logic [31:0] IF_ID_instruction,
  output logic [31:0] IF_ID_pc,
  output logic        IF_ID_take
);

  import rv_pkg::*;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] target;
  logic        take;
  logic [1:0]  bht_ctr;

  assign imem_addr = pc;

  if_bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pc[BHT_IDX_W+1:2]),
    .rd_ctr    (bht_ctr),
    .upd_valid (bht_update_valid),
    .upd_idx   (bht_update_pc[BHT_IDX_W+1:2]),
    .upd_taken (bht_update_taken)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    take   = 1'b0;
    target = pc + imm_b(imem_data);
    case (imem_data[6:0])
      OP_UNCONDITIONAL_JMP: begin
        take   = 1'b1;
        target = pc + imm_j(imem_data);
      end
      OP_CONDITIONAL_JMP: take = bht_ctr[1];
      default: ;
    endcase
  end

  always_comb begin
    if (redirect_valid)  pc_next = {redirect_pc[31:2], 2'b00};
    else if (stall)      pc_next = pc;
    else if (take)       pc_next = target;
    else                 pc_next = pc + 32'd4;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  // A flush overrides stall but keeps IF_ID_pc; only the payload is squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_instruction <= NOP_INSTR;
      IF_ID_pc          <= RESET_PC;
      IF_ID_take        <= 1'b0;
    end else if (redirect_valid) begin
      IF_ID_instruction <= NOP_INSTR;
      IF_ID_take        <= 1'b0;
    end else if (!stall) begin
      IF_ID_instruction <= imem_data;
      IF_ID_pc          <= pc;
      IF_ID_take        <= take;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], bht_update_pc[31:BHT_IDX_W+2],
                         bht_update_pc[1:0], bht_ctr[0]};

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a random run
// against an instruction-level reference model of fetch, prediction and BHT.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_data, redirect_pc, bht_update_pc;
  logic [31:0] IF_ID_instruction, IF_ID_pc;
  logic        stall, redirect_valid, bht_update_valid, bht_update_taken, IF_ID_take;

  always #5 clk = ~clk;

  logic [31:0] prog [64];
  assign imem_data = prog[imem_addr[7:2]];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_ir, m_ipc;
  logic        m_take;
  int          m_bht [64];

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bht_update_valid(bht_update_valid), .bht_update_pc(bht_update_pc),
    .bht_update_taken(bht_update_taken), .IF_ID_instruction(IF_ID_instruction),
    .IF_ID_pc(IF_ID_pc), .IF_ID_take(IF_ID_take)
  );

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] b;
    b = imm[20:0];
    return {b[20], b[10:1], b[11], b[19:12], 5'd0, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_beq(input int imm);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], 5'd0, 5'd0, 3'b000, b[4:1], b[11], 7'h63};
  endfunction

  function automatic int b_off(input logic [31:0] i);
    int v;
    v = i[31] ? -4096 : 0;
    return v + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
  endfunction

  function automatic int j_off(input logic [31:0] i);
    int v;
    v = i[31] ? -1048576 : 0;
    return v + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
  endfunction

  task automatic fill_addi();
    for (int i = 0; i < 64; i++) prog[i] = {12'(i), 5'd1, 3'b000, 5'd1, 7'h13};
  endtask

  task automatic idle_inputs();
    stall = 0; redirect_valid = 0; redirect_pc = 0;
    bht_update_valid = 0; bht_update_pc = 0; bht_update_taken = 0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = NOP; m_ipc = 0; m_take = 0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  // One clock edge: model computes next state from the current inputs, DUT advances.
  task automatic cycle();
    logic [31:0] ins, nxt;
    logic        t;
    int          off, idx;
    ins = prog[m_pc[7:2]];
    t = 0; off = 0;
    if (ins[6:0] == 7'h6F) begin t = 1; off = j_off(ins); end
    else if (ins[6:0] == 7'h63) begin t = (m_bht[m_pc[7:2]] >= 2); off = b_off(ins); end
    if (redirect_valid) nxt = redirect_pc & ~32'h3;
    else if (stall)     nxt = m_pc;
    else if (t)         nxt = m_pc + 32'(off);
    else                nxt = m_pc + 32'd4;
    @(posedge clk);
    #1;
    if (redirect_valid) begin m_ir = NOP; m_take = 0; end
    else if (!stall) begin m_ir = ins; m_ipc = m_pc; m_take = t; end
    if (bht_update_valid) begin
      idx = int'(bht_update_pc[7:2]);
      if (bht_update_taken && m_bht[idx] < 3) m_bht[idx]++;
      else if (!bht_update_taken && m_bht[idx] > 0) m_bht[idx]--;
    end
    m_pc = nxt;
  endtask

  task automatic run_until(input logic [31:0] addr, input int budget);
    int n = 0;
    while (imem_addr !== addr && n < budget) begin cycle(); n++; end
    n_cmp++;
    if (imem_addr !== addr) begin
      n_err++;
      $display("FAIL run_until: imem_addr=%h never reached %h", imem_addr, addr);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    fill_addi();
    rst_n = 0;
    model_reset();
    #12;
    n_cmp++;
    if ({imem_addr, IF_ID_instruction, IF_ID_pc, IF_ID_take} !== {32'h0, NOP, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got %h/%h/%h/%b want 0/%h/0/0",
               imem_addr, IF_ID_instruction, IF_ID_pc, IF_ID_take, NOP);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (imem_addr !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL seq_addr%0d: got %h want %h", k, imem_addr, 32'(4 * k));
      end
      cycle();
      n_cmp++;
      if ({IF_ID_pc, IF_ID_instruction, IF_ID_take} !== {32'(4 * k), prog[k], 1'b0}) begin
        n_err++;
        $display("FAIL seq_ifid%0d: got %h/%h/%b want %h/%h/0",
                 k, IF_ID_pc, IF_ID_instruction, IF_ID_take, 32'(4 * k), prog[k]);
      end
    end
  endtask

  task automatic test_jal();
    do_reset();
    prog[2] = enc_jal(16);
    cycle(); cycle(); cycle();
    n_cmp++;
    if ({imem_addr, IF_ID_pc, IF_ID_take} !== {32'h18, 32'h8, 1'b1}) begin
      n_err++;
      $display("FAIL jal: got addr=%h pc=%h take=%b want 18/8/1", imem_addr, IF_ID_pc, IF_ID_take);
    end
    fill_addi();
  endtask

  task automatic test_bht_train();
    do_reset();
    prog[8] = enc_beq(-8);
    // Updates land while stalled: training must not depend on pipeline flow.
    stall = 1; bht_update_valid = 1; bht_update_pc = 32'h20; bht_update_taken = 1;
    repeat (3) cycle();
    idle_inputs();
    n_cmp++;
    if (imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL bht_stalled_pc: got %h want 0", imem_addr);
    end
    run_until(32'h20, 16);
    cycle();
    n_cmp++;
    if ({imem_addr, IF_ID_pc, IF_ID_take} !== {32'h18, 32'h20, 1'b1}) begin
      n_err++;
      $display("FAIL bht_sat_taken: got %h/%h/%b want 18/20/1", imem_addr, IF_ID_pc, IF_ID_take);
    end
    for (int r = 0; r < 2; r++) begin
      cycle(); cycle();
      bht_update_valid = 1; bht_update_pc = 32'h20; bht_update_taken = 0;
      cycle();
      idle_inputs();
      n_cmp++;
      if ({imem_addr, IF_ID_take} !== {32'h18, 1'b1}) begin
        n_err++;
        $display("FAIL bht_decay%0d: got %h/%b want 18/1", r, imem_addr, IF_ID_take);
      end
    end
    cycle(); cycle(); cycle();
    n_cmp++;
    if ({imem_addr, IF_ID_pc, IF_ID_take} !== {32'h24, 32'h20, 1'b0}) begin
      n_err++;
      $display("FAIL bht_not_taken: got %h/%h/%b want 24/20/0", imem_addr, IF_ID_pc, IF_ID_take);
    end
  endtask

  task automatic test_stall();
    do_reset();
    fill_addi();
    repeat (3) cycle();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_cmp++;
      if ({imem_addr, IF_ID_pc, IF_ID_instruction} !== {32'hC, 32'h8, prog[2]}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got %h/%h/%h want c/8/%h",
                 k, imem_addr, IF_ID_pc, IF_ID_instruction, prog[2]);
      end
    end
    stall = 0;
    cycle();
    n_cmp++;
    if ({imem_addr, IF_ID_pc, IF_ID_instruction} !== {32'h10, 32'hC, prog[3]}) begin
      n_err++;
      $display("FAIL stall_release: got %h/%h/%h want 10/c/%h",
               imem_addr, IF_ID_pc, IF_ID_instruction, prog[3]);
    end
  endtask

  task automatic test_stall_redirect();
    stall = 1; redirect_valid = 1; redirect_pc = 32'h103;
    cycle();
    idle_inputs();
    n_cmp++;
    if ({imem_addr, IF_ID_instruction, IF_ID_take, IF_ID_pc} !== {32'h100, NOP, 1'b0, 32'hC}) begin
      n_err++;
      $display("FAIL flush_over_stall: got %h/%h/%b/%h want 100/%h/0/c",
               imem_addr, IF_ID_instruction, IF_ID_take, IF_ID_pc, NOP);
    end
    cycle();
    n_cmp++;
    if ({imem_addr, IF_ID_pc, IF_ID_instruction} !== {32'h104, 32'h100, prog[0]}) begin
      n_err++;
      $display("FAIL after_redirect: got %h/%h/%h want 104/100/%h",
               imem_addr, IF_ID_pc, IF_ID_instruction, prog[0]);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
    cycle();
    idle_inputs();
    cycle();
    n_cmp++;
    if ({imem_addr, IF_ID_pc} !== {32'h0, 32'hFFFF_FFFC}) begin
      n_err++;
      $display("FAIL pc_wrap: got %h/%h want 0/fffffffc", imem_addr, IF_ID_pc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    prog[8] = enc_beq(-8);
    bht_update_valid = 1; bht_update_pc = 32'h20; bht_update_taken = 1;
    cycle(); cycle();
    idle_inputs();
    run_until(32'h20, 16);
    cycle();
    n_cmp++;
    if ({imem_addr, IF_ID_take} !== {32'h18, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset_taken: got %h/%b want 18/1", imem_addr, IF_ID_take);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if ({imem_addr, IF_ID_instruction, IF_ID_pc, IF_ID_take} !== {32'h0, NOP, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got %h/%h/%h/%b want 0/%h/0/0",
               imem_addr, IF_ID_instruction, IF_ID_pc, IF_ID_take, NOP);
    end
    @(negedge clk);
    rst_n = 1;
    run_until(32'h20, 16);
    cycle();
    n_cmp++;
    if ({imem_addr, IF_ID_take} !== {32'h24, 1'b0}) begin
      n_err++;
      $display("FAIL bht_after_reset: got %h/%b want 24/0", imem_addr, IF_ID_take);
    end
    fill_addi();
  endtask

  task automatic test_random();
    int sel;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2)      prog[i] = enc_jal(int'($urandom_range(0, 32)) * 2 - 32);
      else if (sel < 4) prog[i] = enc_beq(int'($urandom_range(0, 32)) * 2 - 32);
      else              prog[i] = {12'($urandom), 5'd2, 3'b000, 5'd2, 7'h13};
    end
    for (int c = 0; c < 400; c++) begin
      stall            = ($urandom_range(0, 3) == 0);
      redirect_valid   = ($urandom_range(0, 9) == 0);
      redirect_pc      = $urandom_range(0, 255);
      bht_update_valid = ($urandom_range(0, 2) == 0);
      bht_update_pc    = {$urandom_range(0, 63), 2'b00};
      bht_update_taken = $urandom_range(0, 1);
      cycle();
      n_cmp++;
      if ({imem_addr, IF_ID_instruction, IF_ID_pc, IF_ID_take} !== {m_pc, m_ir, m_ipc, m_take}) begin
        n_err++;
        $display("FAIL random_c%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, imem_addr,
                 IF_ID_instruction, IF_ID_pc, IF_ID_take, m_pc, m_ir, m_ipc, m_take);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_bht_train();
    test_stall();
    test_stall_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
